down_timer: RTL and testbench

Loadable down-counting timer with a synchronous active-high clear. It is the consumer-side counterpart of the team's saturating up counter: instead of counting events up to a ceiling, it is loaded with a value, counts down to zero and signals terminal count. It runs in one-shot or periodic (auto-reload) mode, and a fixed prescaler sets the decrement rate. It serves as the timeout, delay and baud/tick generator for control FSMs in the design.

---
 rtl/down_timer.sv | 80 ++++++++
 tb/tb_down_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot / periodic modes
// and a fixed prescaler. Used as timeout, delay and tick source for FSMs.
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Prescaler compare value; the prescaler counter is fixed at 8 bits.
  localparam logic [7:0] PRE_MAX = 8'(PRESCALE);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [0:0]       state;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic [7:0]       pre;
  logic             tick;

  // A decrement opportunity occurs once the prescaler reaches its limit.
  assign tick = (pre == PRE_MAX);

  // Status decodes straight from the registers.
  assign busy = (state == RUN);
  assign zero = (count == '0);

  // Timer state: clear beats load, load beats counting; tc is a one-cycle pulse.
  always_ff @(posedge clk) begin
    tc <= 1'b0;
    if (clr) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      pre    <= '0;
    end else if (load) begin
      // Load restarts from any state; a zero value parks the timer silently.
      count  <= load_value;
      reload <= load_value;
      mode   <= periodic;
      pre    <= '0;
      state  <= (load_value != '0) ? RUN : IDLE;
    end else if (state == RUN && en) begin
      if (tick) begin
        pre <= '0;
        if (count > ONE) begin
          count <= count - ONE;
        end else if (count == ONE) begin
          tc <= 1'b1;
          if (mode) begin
            // Periodic: jump straight back to the reload value, never showing 0.
            count <= reload;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end else begin
          // Unreachable in normal operation; never wrap below zero.
          state <= IDLE;
        end
      end else begin
        pre <= pre + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer. Two instances share the
// stimulus: u0 with PRESCALE=0 and u2 with PRESCALE=2.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       periodic = 1'b0;
  logic       en = 1'b0;

  logic [7:0] count0, count2;
  logic       busy0, busy2, tc0, tc2, zero0, zero2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(8), .PRESCALE(0)) u0 (
    .clk(clk), .clr(clr), .load(load), .load_value(load_value),
    .periodic(periodic), .en(en),
    .count(count0), .busy(busy0), .tc(tc0), .zero(zero0)
  );

  down_timer #(.WIDTH(8), .PRESCALE(2)) u2 (
    .clk(clk), .clr(clr), .load(load), .load_value(load_value),
    .periodic(periodic), .en(en),
    .count(count2), .busy(busy2), .tc(tc2), .zero(zero2)
  );

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic p);
    load = 1'b1; load_value = v; periodic = p;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      clr = 1'b1;
      load = 1'($urandom); load_value = 8'($urandom);
      periodic = 1'($urandom); en = 1'($urandom);
      step();
      checks++;
      if (count0 !== 8'd0 || busy0 !== 1'b0 || tc0 !== 1'b0 || zero0 !== 1'b1) begin
        errors++;
        $display("FAIL reset_u0 cyc%0d count=%0d busy=%b tc=%b zero=%b exp 0/0/0/1", i, count0, busy0, tc0, zero0);
      end
      checks++;
      if (count2 !== 8'd0 || busy2 !== 1'b0 || tc2 !== 1'b0 || zero2 !== 1'b1) begin
        errors++;
        $display("FAIL reset_u2 cyc%0d count=%0d busy=%b tc=%b zero=%b exp 0/0/0/1", i, count2, busy2, tc2, zero2);
      end
    end
    clr = 1'b0; load = 1'b0; en = 1'b0; periodic = 1'b0; load_value = 8'd0;
  endtask

  task automatic test_oneshot();
    en = 1'b1;
    do_load(8'd5, 1'b0);
    checks++;
    if (count0 !== 8'd5 || busy0 !== 1'b1 || tc0 !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_load count=%0d busy=%b tc=%b exp 5/1/0", count0, busy0, tc0);
    end
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] ec;
      step();
      ec = (i <= 5) ? 8'(5 - i) : 8'd0;
      checks++;
      if (count0 !== ec || tc0 !== (i == 5) || busy0 !== (i < 5)) begin
        errors++;
        $display("FAIL oneshot_cyc%0d count=%0d tc=%b busy=%b exp %0d/%b/%b", i, count0, tc0, busy0, ec, (i == 5), (i < 5));
      end
    end
  endtask

  task automatic test_periodic();
    en = 1'b1;
    do_load(8'd3, 1'b1);
    checks++;
    if (count2 !== 8'd3 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL periodic_load count=%0d busy=%b exp 3/1", count2, busy2);
    end
    // Each value held 3 cycles: 3,3,3,2,2,2,1,1,1,3,... tc on every 9th edge.
    for (int c = 1; c <= 36; c++) begin
      logic [7:0] ec;
      step();
      ec = 8'(3 - ((c / 3) % 3));
      checks++;
      if (count2 !== ec || tc2 !== ((c % 9) == 0) || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL periodic_cyc%0d count=%0d tc=%b busy=%b exp %0d/%b/1", c, count2, tc2, busy2, ec, ((c % 9) == 0));
      end
    end
    // Leave the periodic timers stopped.
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_pause();
    // Expected after each post-load edge: 3,2,(pause)2,2,2,1,0
    logic [7:0] exp_c [1:7] = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0};
    en = 1'b1;
    do_load(8'd4, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      en = !(c >= 3 && c <= 5);
      step();
      checks++;
      if (count0 !== exp_c[c] || tc0 !== (c == 7)) begin
        errors++;
        $display("FAIL pause_cyc%0d count=%0d tc=%b exp %0d/%b", c, count0, tc0, exp_c[c], (c == 7));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_boundaries();
    en = 1'b1;
    do_load(8'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      checks++;
      if (count0 !== 8'd0 || busy0 !== 1'b0 || tc0 !== 1'b0 || zero0 !== 1'b1) begin
        errors++;
        $display("FAIL load0_cyc%0d count=%0d busy=%b tc=%b zero=%b exp 0/0/0/1", c, count0, busy0, tc0, zero0);
      end
    end
    do_load(8'd255, 1'b0);
    checks++;
    if (count0 !== 8'd255 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL load255 count=%0d busy=%b exp 255/1", count0, busy0);
    end
    for (int c = 1; c <= 258; c++) begin
      logic [7:0] ec;
      step();
      ec = (c <= 255) ? 8'(255 - c) : 8'd0;
      checks++;
      if (count0 !== ec || tc0 !== (c == 255)) begin
        errors++;
        $display("FAIL max_cyc%0d count=%0d tc=%b exp %0d/%b", c, count0, tc0, ec, (c == 255));
      end
    end
    do_load(8'd1, 1'b0);
    checks++;
    if (count0 !== 8'd1 || tc0 !== 1'b0) begin
      errors++;
      $display("FAIL load1 count=%0d tc=%b exp 1/0", count0, tc0);
    end
    step();
    checks++;
    if (count0 !== 8'd0 || tc0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL load1_tc count=%0d tc=%b busy=%b exp 0/1/0", count0, tc0, busy0);
    end
  endtask

  task automatic test_collisions();
    en = 1'b1;
    // load on the terminal-tick edge
    do_load(8'd3, 1'b0);
    step(); step();
    do_load(8'd2, 1'b0);
    checks++;
    if (count0 !== 8'd2 || tc0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL load_on_tc count=%0d tc=%b busy=%b exp 2/0/1", count0, tc0, busy0);
    end
    step();
    step();
    checks++;
    if (count0 !== 8'd0 || tc0 !== 1'b1) begin
      errors++;
      $display("FAIL load_on_tc_after count=%0d tc=%b exp 0/1", count0, tc0);
    end
    // clr on the terminal-tick edge
    do_load(8'd2, 1'b0);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (count0 !== 8'd0 || tc0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_on_tc count=%0d tc=%b busy=%b exp 0/0/0", count0, tc0, busy0);
    end
    step();
    checks++;
    if (count0 !== 8'd0 || tc0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_on_tc_after count=%0d tc=%b busy=%b exp 0/0/0", count0, tc0, busy0);
    end
    // load mid-count restarts
    do_load(8'd5, 1'b0);
    step();
    do_load(8'd3, 1'b0);
    checks++;
    if (count0 !== 8'd3 || tc0 !== 1'b0) begin
      errors++;
      $display("FAIL restart count=%0d tc=%b exp 3/0", count0, tc0);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (count0 !== 8'(3 - c) || tc0 !== (c == 3)) begin
        errors++;
        $display("FAIL restart_cyc%0d count=%0d tc=%b exp %0d/%b", c, count0, tc0, 3 - c, (c == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_boundaries();
    test_collisions();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
